// File: rtl/decode_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | decode_queue : RV32I(+M) decoder feeding a DEPTH-entry FIFO toward issue    |
// | rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module decode_queue #(
  parameter int DEPTH    = 8,
  parameter int ENABLE_M = 0,
  parameter int TYPE_W   = 6,
  parameter int REG_W    = 6
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     in_valid,
  input  logic [31:0]              in_code,
  input  logic [31:0]              in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TYPE_W-1:0]        out_type,
  output logic [REG_W-1:0]         out_rd,
  output logic [REG_W-1:0]         out_rs1,
  output logic [REG_W-1:0]         out_rs2,
  output logic [31:0]              out_imm,
  output logic [31:0]              out_pc,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [REG_W-1:0] NO_REG = REG_W'(32);

  // Instruction type codes shared with the issue stage
  localparam logic [7:0] T_LUI  = 8'd1,  T_AUIPC = 8'd2,  T_JAL   = 8'd3,  T_JALR  = 8'd4;
  localparam logic [7:0] T_BEQ  = 8'd5,  T_BNE   = 8'd6,  T_BLT   = 8'd7,  T_BGE   = 8'd8;
  localparam logic [7:0] T_BLTU = 8'd9,  T_BGEU  = 8'd10, T_LB    = 8'd11, T_LH    = 8'd12;
  localparam logic [7:0] T_LW   = 8'd13, T_LBU   = 8'd14, T_LHU   = 8'd15, T_SB    = 8'd16;
  localparam logic [7:0] T_SH   = 8'd17, T_SW    = 8'd18, T_ADDI  = 8'd19, T_SLTI  = 8'd20;
  localparam logic [7:0] T_SLTIU= 8'd21, T_XORI  = 8'd22, T_ORI   = 8'd23, T_ANDI  = 8'd24;
  localparam logic [7:0] T_SLLI = 8'd25, T_SRLI  = 8'd26, T_SRAI  = 8'd27, T_ADD   = 8'd28;
  localparam logic [7:0] T_SUB  = 8'd29, T_SLL   = 8'd30, T_SLT   = 8'd31, T_SLTU  = 8'd32;
  localparam logic [7:0] T_XOR  = 8'd33, T_SRL   = 8'd34, T_SRA   = 8'd35, T_OR    = 8'd36;
  localparam logic [7:0] T_AND  = 8'd37, T_MUL   = 8'd38;

  typedef enum logic [2:0] {IMM_ZERO, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SH} imm_sel_e;

  typedef struct packed {
    logic [TYPE_W-1:0] ty;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [31:0]       imm;
    logic [31:0]       pc;
    logic              illegal;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opcode = in_code[6:0];
  assign f3     = in_code[14:12];
  assign f7     = in_code[31:25];

  logic [7:0] dec_ty;
  imm_sel_e   imm_sel;
  logic       use_rd, use_rs1, use_rs2, legal;
  logic [31:0] imm_val;
  entry_t     wr_entry;

  always_comb begin
    dec_ty  = 8'd0;
    imm_sel = IMM_ZERO;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    legal   = 1'b1;
    case (opcode)
      7'h37: begin dec_ty = T_LUI;   imm_sel = IMM_U; use_rd = 1'b1; end
      7'h17: begin dec_ty = T_AUIPC; imm_sel = IMM_U; use_rd = 1'b1; end
      7'h6F: begin dec_ty = T_JAL;   imm_sel = IMM_J; use_rd = 1'b1; end
      7'h67: begin
        dec_ty = T_JALR; imm_sel = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
        legal  = (f3 == 3'd0);
      end
      7'h63: begin
        imm_sel = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3)
          3'd0:    dec_ty = T_BEQ;
          3'd1:    dec_ty = T_BNE;
          3'd4:    dec_ty = T_BLT;
          3'd5:    dec_ty = T_BGE;
          3'd6:    dec_ty = T_BLTU;
          3'd7:    dec_ty = T_BGEU;
          default: legal  = 1'b0;
        endcase
      end
      7'h03: begin
        imm_sel = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
        case (f3)
          3'd0:    dec_ty = T_LB;
          3'd1:    dec_ty = T_LH;
          3'd2:    dec_ty = T_LW;
          3'd4:    dec_ty = T_LBU;
          3'd5:    dec_ty = T_LHU;
          default: legal  = 1'b0;
        endcase
      end
      7'h23: begin
        imm_sel = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3)
          3'd0:    dec_ty = T_SB;
          3'd1:    dec_ty = T_SH;
          3'd2:    dec_ty = T_SW;
          default: legal  = 1'b0;
        endcase
      end
      7'h13: begin
        imm_sel = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1;
        case (f3)
          3'd0: dec_ty = T_ADDI;
          3'd2: dec_ty = T_SLTI;
          3'd3: dec_ty = T_SLTIU;
          3'd4: dec_ty = T_XORI;
          3'd6: dec_ty = T_ORI;
          3'd7: dec_ty = T_ANDI;
          3'd1: begin
            imm_sel = IMM_SH; dec_ty = T_SLLI;
            legal   = (f7 == 7'h00);
          end
          default: begin
            imm_sel = IMM_SH;
            if (f7 == 7'h00)      dec_ty = T_SRLI;
            else if (f7 == 7'h20) dec_ty = T_SRAI;
            else                  legal  = 1'b0;
          end
        endcase
      end
      7'h33: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        if (f7 == 7'h00) begin
          case (f3)
            3'd0:    dec_ty = T_ADD;
            3'd1:    dec_ty = T_SLL;
            3'd2:    dec_ty = T_SLT;
            3'd3:    dec_ty = T_SLTU;
            3'd4:    dec_ty = T_XOR;
            3'd5:    dec_ty = T_SRL;
            3'd6:    dec_ty = T_OR;
            default: dec_ty = T_AND;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
          dec_ty = T_SUB;
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
          dec_ty = T_SRA;
        end else if (f7 == 7'h01 && ENABLE_M != 0) begin
          dec_ty = T_MUL + {5'd0, f3};
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    case (imm_sel)
      IMM_I:   imm_val = {{20{in_code[31]}}, in_code[31:20]};
      IMM_S:   imm_val = {{20{in_code[31]}}, in_code[31:25], in_code[11:7]};
      IMM_B:   imm_val = {{19{in_code[31]}}, in_code[31], in_code[7], in_code[30:25],
                          in_code[11:8], 1'b0};
      IMM_U:   imm_val = {in_code[31:12], 12'b0};
      IMM_J:   imm_val = {{11{in_code[31]}}, in_code[31], in_code[19:12], in_code[20],
                          in_code[30:21], 1'b0};
      IMM_SH:  imm_val = {27'b0, in_code[24:20]};
      default: imm_val = 32'b0;
    endcase
  end

  always_comb begin
    wr_entry.pc = in_pc;
    if (legal) begin
      wr_entry.ty      = TYPE_W'(dec_ty);
      wr_entry.rd      = use_rd  ? REG_W'(in_code[11:7])  : NO_REG;
      wr_entry.rs1     = use_rs1 ? REG_W'(in_code[19:15]) : NO_REG;
      wr_entry.rs2     = use_rs2 ? REG_W'(in_code[24:20]) : NO_REG;
      wr_entry.imm     = imm_val;
      wr_entry.illegal = 1'b0;
    end else begin
      wr_entry.ty      = '0;
      wr_entry.rd      = NO_REG;
      wr_entry.rs1     = NO_REG;
      wr_entry.rs2     = NO_REG;
      wr_entry.imm     = 32'b0;
      wr_entry.illegal = 1'b1;
    end
  end

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;

  assign in_ready  = rdy_in & ~rst_in & (count_q < CW'(DEPTH));
  assign out_valid = rdy_in & (count_q != '0);
  assign push      = in_valid & in_ready & ~flush_in;
  assign pop       = out_valid & out_ready & ~flush_in;

  // Flush rewinds pointers but leaves storage alone; stale entries are unreachable
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rdy_in) begin
      if (flush_in) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (push) begin
          mem_d[wr_ptr_q] = wr_entry;
          wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
          2'b10:   count_d = count_q + CW'(1);
          2'b01:   count_d = count_q - CW'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  entry_t head;
  assign head        = mem_q[rd_ptr_q];
  assign out_type    = head.ty;
  assign out_rd      = head.rd;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_imm     = head.imm;
  assign out_pc      = head.pc;
  assign out_illegal = head.illegal;
  assign count       = count_q;

endmodule
`default_nettype wire
